ct_merge_arb: RTL and testbench
===============================

CT_MERGE_ARB -- requirements
Module: ct_merge_arb

Interface
- REQ-001 Parameter: NI, none, number of inputs (2..16).
- REQ-002 Parameter: WO, none, width of the data word on every input and on the output.
- REQ-003 Parameter: EOP_LOC, none, bit location of the end-of-packet flag within the data word.
- REQ-004 Port: clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-005 Port: reset, input, 1, reset, synchronous and active-low; asserted when low, sampled on the clk rising edge.
- REQ-006 Port: i_data, input, NI*WO, input words; input k occupies bits [k*WO +: WO].
- REQ-007 Port: i_valid, input, NI, per-input valid.
- REQ-008 Port: o_ready, output, NI, per-input ready (backpressure to each requester).
- REQ-009 Port: o_data, output, WO, merged output word.
- REQ-010 Port: o_valid, output, 1, output valid.
- REQ-011 Port: i_ready, input, 1, downstream ready.
- REQ-012 Port: o_grant, output, NI, one-hot current grant; zero when no grant is held.
- REQ-013 Port: o_locked, output, 1, high while a multi-beat packet holds the arbiter.

Function
- REQ-014 Transfer rule: a beat transfers on input k when i_valid[k] and o_ready[k] are both high in the same cycle.
- REQ-015 The arbiter SHALL have two states: IDLE and LOCKED. It holds a priority pointer ptr (0..NI-1) and a locked index lk.
- REQ-016 IDLE grant:
  - the granted input is the first input with i_valid high, searching ptr, ptr+1, ... modulo NI;
  - the grant is combinational in the same cycle;
  - if no input is valid, there is no grant.
- REQ-017 LOCKED grant: only input lk is granted, whether or not it is valid; all other inputs see o_ready low.
- REQ-018 IDLE, granted beat transfers:
  - eop=0: go to LOCKED with lk = granted index;
  - eop=1: stay IDLE and set ptr = granted+1 modulo NI.
- REQ-019 LOCKED, beat transfers with eop=1: go to IDLE and set ptr = lk+1 modulo NI. Otherwise stay LOCKED.
- REQ-020 Non-granted inputs SHALL see o_ready low. The granted input's o_ready SHALL equal the readiness of the output stage.
- REQ-021 o_data SHALL carry the granted input's word unmodified. o_valid SHALL be the granted input's i_valid, through the output stage.
- REQ-022 No packet interleaving: beats of one packet SHALL never be separated by beats from another input.
- REQ-023 A deasserted i_valid[lk] while LOCKED (bubble) SHALL hold the lock without advancing ptr.
- REQ-024 o_locked SHALL be high exactly in state LOCKED.
- REQ-025 o_grant SHALL be one-hot at lk in LOCKED, one-hot at the IDLE winner, and zero otherwise.

Reset
- REQ-026 While reset is low at a clk edge:
  - state = IDLE, ptr = 0, lk = 0;
  - the output register (if present) is emptied, so o_valid = 0;
  - o_locked = 0.
- REQ-027 During reset, o_ready SHALL be all zero. A reset arriving mid-packet SHALL abandon the lock, with no beat transferred in that cycle.

Configuration
- REQ-028 Macro CT_MERGE_ARB_OREG_EN defined: a one-entry output register sits between the arbiter and o_data/o_valid.
  - It loads when empty or when i_ready is high; the output-stage readiness is (!o_valid | i_ready).
  - Latency is 1 cycle, with full throughput of 1 beat per cycle.
- REQ-029 Macro CT_MERGE_ARB_OREG_EN undefined: o_data/o_valid are combinational from the granted input, output-stage readiness is i_ready, and latency is 0 cycles.
- REQ-030 State and grant behaviour (REQ-015..025) SHALL be identical in both builds; only output timing differs.

Verification
- REQ-031 NI=4, i_ready=1, all inputs present single-beat packets (eop=1) every cycle -> grants 0,1,2,3,0,... one beat per cycle, o_locked stays 0.
- REQ-032 Input 2 sends a 3-beat packet (eop on beat 3) while input 0 is continuously valid -> the output carries beats 2a,2b,2c contiguously, then input 0; ptr=3 after the packet.
- REQ-033 Locked on input 1 with i_valid[1] low for 2 cycles and input 3 valid -> o_ready[3]=0 throughout, o_locked=1, no beat from input 3 until input 1's eop transfers.
- REQ-034 i_ready held 0 for 5 cycles with input 0 valid -> o_data stable, no transfer, state unchanged; the beat transfers on the first cycle with i_ready=1.
- REQ-035 reset driven low for one edge mid-packet (LOCKED on input 2) -> next cycle: state IDLE, ptr=0, o_valid=0, o_grant=0.
- REQ-036 Both builds (macro defined and undefined), same stimulus -> identical output beat sequence; the OREG build is delayed by exactly 1 cycle.

Source files
------------

// File: rtl/ct_merge_arb_if.sv
// ct_merge_arb_if: request/merge bus of the ct_merge_arb packet arbiter.
// slave = arbiter view, master = requester/downstream (bench) view.
interface ct_merge_arb_if #(
  parameter int unsigned NI = 4,
  parameter int unsigned WO = 8
);
  logic [NI*WO-1:0] i_data;
  logic [NI-1:0]    i_valid;
  logic [NI-1:0]    o_ready;
  logic [WO-1:0]    o_data;
  logic             o_valid;
  logic             i_ready;
  logic [NI-1:0]    o_grant;
  logic             o_locked;

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_grant, o_locked
  );

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_grant, o_locked
  );
endinterface

// File: rtl/ct_merge_arb.sv
// ct_merge_arb: NI-input round-robin merge arbiter that keeps multi-beat
// packets contiguous (lock from first beat until the eop beat transfers).
// Optional feature macro: CT_MERGE_ARB_OREG_EN adds a one-entry output
// register (1 cycle latency, full throughput); undefined = combinational output.
module ct_merge_arb #(
  parameter int unsigned NI      = 4,
  parameter int unsigned WO      = 8,
  parameter int unsigned EOP_LOC = WO - 1
) (
  input  logic          clk,
  input  logic          reset,
  ct_merge_arb_if.slave bus
);

  localparam int unsigned PW = (NI > 1) ? $clog2(NI) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] lk;

  logic [PW-1:0] win_idx;
  logic          win_any;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic [NI-1:0] grant;
  logic [WO-1:0] sel_data;
  logic          sel_valid;
  logic          sel_eop;
  logic          stage_rdy;
  logic          xfer;

  // Round-robin search: first valid input starting at ptr (reverse scan keeps the first hit).
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int off = int'(NI) - 1; off >= 0; off--) begin
      if (bus.i_valid[PW'((int'(ptr) + off) % int'(NI))]) begin
        win_any = 1'b1;
        win_idx = PW'((int'(ptr) + off) % int'(NI));
      end
    end
  end

  // Grant owner: locked input while LOCKED, search winner while IDLE, nobody in reset.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = win_idx;
    if (reset) begin
      if (state == LOCKED) begin
        gnt_any = 1'b1;
        gnt_idx = lk;
      end else begin
        gnt_any = win_any;
      end
    end
  end

  // One-hot grant vector and data mux of the granted input.
  always_comb begin
    grant    = '0;
    sel_data = '0;
    for (int k = 0; k < int'(NI); k++) begin
      if (gnt_any && (PW'(k) == gnt_idx)) begin
        grant[k] = 1'b1;
        sel_data = bus.i_data[k*WO +: WO];
      end
    end
  end

  assign sel_valid = gnt_any & bus.i_valid[gnt_idx];
  assign sel_eop   = sel_data[EOP_LOC];
  assign xfer      = sel_valid & stage_rdy;

`ifdef CT_MERGE_ARB_OREG_EN
  logic [WO-1:0] data_q;
  logic          valid_q;

  assign stage_rdy = ~valid_q | bus.i_ready;

  // One-entry output register: refills whenever it is empty or being drained.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (stage_rdy) begin
      valid_q <= sel_valid;
      data_q  <= sel_data;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
`else
  assign stage_rdy   = bus.i_ready;
  assign bus.o_valid = sel_valid;
  assign bus.o_data  = sel_data;
`endif

  // Arbiter state: lock on a non-eop beat, release and rotate ptr on the eop beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      lk    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            if (sel_eop) begin
              ptr <= PW'((int'(gnt_idx) + 1) % int'(NI));
            end else begin
              state <= LOCKED;
              lk    <= gnt_idx;
            end
          end
        end
        LOCKED: begin
          if (xfer && sel_eop) begin
            state <= IDLE;
            ptr   <= PW'((int'(lk) + 1) % int'(NI));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready  = grant & {NI{stage_rdy}};
  assign bus.o_grant  = grant;
  assign bus.o_locked = (state == LOCKED);

endmodule

// File: tb/tb_ct_merge_arb.sv
// tb_ct_merge_arb: directed table + hand sequences + random traffic for ct_merge_arb,
// checked against a packet-level reference model (owner/pointer bookkeeping).
module tb_ct_merge_arb;

  localparam int unsigned NI      = 4;
  localparam int unsigned WO      = 8;
  localparam int unsigned EOP_LOC = 7;
`ifdef CT_MERGE_ARB_OREG_EN
  localparam bit OREG = 1'b1;
`else
  localparam bit OREG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  ct_merge_arb_if #(.NI(NI), .WO(WO)) bus ();

  ct_merge_arb #(.NI(NI), .WO(WO), .EOP_LOC(EOP_LOC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner of the output (-1 = free), rotation pointer, output register copy.
  int         m_owner = -1;
  int         m_ptr   = 0;
  bit         m_qv    = 1'b0;
  logic [7:0] m_qd    = 8'h00;

  // Stimulus for the next cycle.
  logic [3:0] d_valid;
  logic [7:0] d_word [4];
  logic       d_rdy;
  logic       d_rst;

  // DUT outputs sampled in the last cycle.
  logic [3:0] s_grant, s_ready;
  logic       s_valid, s_locked;
  logic [7:0] s_data;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] eop;
    logic [3:0] grant;
    logic [3:0] ready;
    logic       ovalid;
    logic [1:0] osrc;
    logic       locked;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [7:0] mkw(input int src, input int seq, input logic eop);
    logic [7:0] w;
    w = {eop, 2'(src), 5'(seq)};
    return w;
  endfunction

  function automatic vec_t mkv(input logic [3:0] valid, input logic [3:0] eop,
                               input logic [3:0] grant, input logic [3:0] ready,
                               input logic ovalid, input logic [1:0] osrc,
                               input logic locked);
    vec_t v;
    v.valid = valid; v.eop = eop; v.grant = grant; v.ready = ready;
    v.ovalid = ovalid; v.osrc = osrc; v.locked = locked;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply d_* for one cycle, check against the model, then advance the model.
  task automatic cycle();
    int         g;
    int         idx;
    bit         srdy;
    logic [3:0] e_grant, e_ready;
    logic       e_valid;
    logic [7:0] e_data;
    @(negedge clk);
    reset        = d_rst;
    bus.i_valid  = d_valid;
    bus.i_ready  = d_rdy;
    for (int k = 0; k < 4; k++) bus.i_data[k*8 +: 8] = d_word[k];

    g = -1;
    if (d_rst) begin
      if (m_owner >= 0) g = m_owner;
      else begin
        for (int off = 0; off < 4; off++) begin
          idx = (m_ptr + off) % 4;
          if (g < 0 && d_valid[2'(idx)]) g = idx;
        end
      end
    end
    srdy    = OREG ? (!m_qv || d_rdy) : d_rdy;
    e_grant = (g >= 0) ? 4'(1 << g) : 4'b0000;
    e_ready = srdy ? e_grant : 4'b0000;
    e_valid = OREG ? m_qv : (g >= 0 && d_valid[2'(g)]);
    e_data  = OREG ? m_qd : ((g >= 0) ? d_word[2'(g)] : 8'h00);

    #1;
    s_grant  = bus.o_grant;
    s_ready  = bus.o_ready;
    s_valid  = bus.o_valid;
    s_locked = bus.o_locked;
    s_data   = bus.o_data;
    chk("model_grant",  32'(s_grant),  32'(e_grant));
    chk("model_ready",  32'(s_ready),  32'(e_ready));
    chk("model_locked", 32'(s_locked), 32'(m_owner >= 0));
    chk("model_valid",  32'(s_valid),  32'(e_valid));
    if (e_valid) chk("model_data", 32'(s_data), 32'(e_data));

    @(posedge clk);
    if (!d_rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_qv    = 1'b0;
    end else begin
      if (OREG && srdy) begin
        m_qv = (g >= 0) && d_valid[2'(g)];
        if (g >= 0) m_qd = d_word[2'(g)];
      end
      if (g >= 0 && d_valid[2'(g)] && srdy) begin
        if (d_word[2'(g)][EOP_LOC]) begin
          m_owner = -1;
          m_ptr   = (g + 1) % 4;
        end else begin
          m_owner = g;
        end
      end
    end
  endtask

  initial begin
    logic       prev_v;
    logic [7:0] prev_d, cur_d, ev_d;
    logic       ev_v;

    // Round robin over single-beat packets.
    for (int i = 0; i < 8; i++)
      tbl[i] = mkv(4'hF, 4'hF, 4'(1 << (i % 4)), 4'(1 << (i % 4)), 1'b1, 2'(i % 4), 1'b0);
    // Three-beat packet on input 2 with input 0 constantly requesting.
    tbl[8]  = mkv(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0);
    tbl[9]  = mkv(4'b0101, 4'b0001, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0);
    tbl[10] = mkv(4'b0101, 4'b0001, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1);
    tbl[11] = mkv(4'b0101, 4'b0101, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1);
    tbl[12] = mkv(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0);
    // Lock on input 1 with a two-cycle bubble while input 3 waits.
    tbl[13] = mkv(4'b1010, 4'b1000, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0);
    tbl[14] = mkv(4'b1000, 4'b1000, 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b1);
    tbl[15] = mkv(4'b1000, 4'b1000, 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b1);
    tbl[16] = mkv(4'b1010, 4'b1010, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1);
    tbl[17] = mkv(4'b1000, 4'b1000, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0);

    // Unchecked power-up reset.
    reset       = 1'b0;
    bus.i_valid = '0;
    bus.i_ready = 1'b1;
    bus.i_data  = '0;
    d_valid = '0; d_rdy = 1'b1; d_rst = 1'b0;
    for (int k = 0; k < 4; k++) d_word[k] = 8'h00;
    repeat (2) @(posedge clk);

    // Reset-held cycle and first idle cycle.
    cycle();
    chk("rst_ready", 32'(s_ready), 32'h0);
    d_rst = 1'b1;
    cycle();
    chk("idle_grant",  32'(s_grant),  32'h0);
    chk("idle_locked", 32'(s_locked), 32'h0);
    chk("idle_valid",  32'(s_valid),  32'h0);

    // Directed table.
    prev_v = 1'b0;
    prev_d = 8'h00;
    for (int i = 0; i < 18; i++) begin
      d_valid = tbl[i].valid;
      d_rdy   = 1'b1;
      d_rst   = 1'b1;
      for (int k = 0; k < 4; k++) d_word[k] = mkw(k, i, tbl[i].eop[k]);
      cycle();
      cur_d = mkw(int'(tbl[i].osrc), i, tbl[i].eop[tbl[i].osrc]);
      ev_v  = OREG ? prev_v : tbl[i].ovalid;
      ev_d  = OREG ? prev_d : cur_d;
      chk($sformatf("tbl%0d_grant", i),  32'(s_grant),  32'(tbl[i].grant));
      chk($sformatf("tbl%0d_ready", i),  32'(s_ready),  32'(tbl[i].ready));
      chk($sformatf("tbl%0d_locked", i), 32'(s_locked), 32'(tbl[i].locked));
      chk($sformatf("tbl%0d_valid", i),  32'(s_valid),  32'(ev_v));
      if (ev_v) chk($sformatf("tbl%0d_data", i), 32'(s_data), 32'(ev_d));
      prev_v = tbl[i].ovalid;
      prev_d = cur_d;
    end

    // Downstream stall: five cycles of i_ready low, then the beat drains.
    d_valid = 4'b0001;
    d_word[0] = mkw(0, 20, 1'b1);
    d_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_ready", 32'(s_ready), 32'h0);
      chk("stall_grant", 32'(s_grant), 32'h1);
    end
    d_rdy = 1'b1;
    cycle();
    chk("drain_ready", 32'(s_ready), 32'h1);
    d_valid = 4'hF;
    for (int k = 0; k < 4; k++) d_word[k] = mkw(k, 21, 1'b1);
    cycle();
    chk("after_stall_grant", 32'(s_grant), 32'h2);

    // Reset in the middle of a packet locked on input 2.
    d_valid = 4'b0100;
    d_word[2] = mkw(2, 22, 1'b0);
    cycle();
    chk("pre_rst_grant", 32'(s_grant), 32'h4);
    d_rst = 1'b0;
    d_word[2] = mkw(2, 23, 1'b0);
    cycle();
    chk("midrst_ready", 32'(s_ready), 32'h0);
    chk("midrst_grant", 32'(s_grant), 32'h0);
    d_rst   = 1'b1;
    d_valid = 4'b0000;
    cycle();
    chk("postrst_locked", 32'(s_locked), 32'h0);
    chk("postrst_valid",  32'(s_valid),  32'h0);
    chk("postrst_grant",  32'(s_grant),  32'h0);
    d_valid = 4'b0011;
    for (int k = 0; k < 4; k++) d_word[k] = mkw(k, 24, 1'b1);
    cycle();
    chk("postrst_ptr0", 32'(s_grant), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      d_rst   = ($urandom_range(0, 99) != 0);
      d_valid = 4'($urandom_range(0, 15));
      d_rdy   = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++)
        d_word[k] = mkw(k, int'($urandom_range(0, 31)), $urandom_range(0, 2) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
